// File: rtl/seq_detect_prog_pkg.sv
// Shared constants and helpers for the programmable serial sequence detector.
package seq_det_pkg;

  localparam logic [3:0] PAT_RST_DEF = 4'b1100;

  // Bits needed to hold a match depth of 0..n inclusive.
  function automatic int state_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_detect_prog_if.sv
// Data, control and result signals of the sequence detector, bundled for port lists.
interface seq_detect_prog_if #(
  parameter int N  = 4,
  parameter int CW = 8
);

  logic          x;
  logic          en;
  logic          load;
  logic [N-1:0]  pattern;
  logic          overlap;
  logic          clr_cnt;
  logic          z;
  logic [CW-1:0] count;

  modport master (
    output x, en, load, pattern, overlap, clr_cnt,
    input  z, count
  );

  modport slave (
    input  x, en, load, pattern, overlap, clr_cnt,
    output z, count
  );

endinterface

// File: rtl/seq_detect_prog_next_state.sv
// Combinational next-match-depth search: longest pattern prefix that is a
// suffix of (matched prefix followed by the new bit).
module seq_next_state
  import seq_det_pkg::*;
#(
  parameter int N = 4,
  localparam int SW = state_width(N)
) (
  input  logic [N-1:0]  pat,
  input  logic [SW-1:0] k,
  input  logic          x,
  input  logic          overlap,
  output logic [SW-1:0] k_next
);

  int         kk;
  logic [N:0] s;
  logic [N:0] mask;
  logic [N:0] pre;
  logic       done;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    k_next = '0;
    done   = 1'b0;
    mask   = '0;
    pre    = '0;

    // Leaving the detect state without overlap restarts from an empty match.
    kk = (int'(k) == N && !overlap) ? 0 : int'(k);

    // Candidate string: first kk pattern bits, then x, right-aligned.
    s = {1'b0, pat} >> (N - kk);
    s = {s[N-1:0], x};

    for (int j = N; j >= 1; j--) begin
      mask = {(N + 1){1'b1}} >> (N + 1 - j);
      pre  = {1'b0, pat} >> (N - j);
      if (!done && j <= kk + 1 && (s & mask) == pre) begin
        k_next = SW'(j);
        done   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable Moore sequence detector with overlap select and a
// saturating match counter.
module seq_detect_prog
  import seq_det_pkg::*;
#(
  parameter int           N       = 4,
  parameter int           CW      = 8,
  parameter logic [N-1:0] PAT_RST = N'(PAT_RST_DEF)
) (
  input logic               clk,
  input logic               rst_n,
  seq_detect_prog_if.slave  bus
);

  localparam int              SW    = state_width(N);
  localparam logic [SW-1:0]   K_DET = SW'(N);

  logic [SW-1:0] k_q;
  logic [SW-1:0] k_nxt;
  logic [N-1:0]  pat_q;
  logic          z_q;
  logic [CW-1:0] cnt_q;
  logic          accept;
  logic          hit;

  seq_next_state #(.N(N)) u_next (
    .pat     (pat_q),
    .k       (k_q),
    .x       (bus.x),
    .overlap (bus.overlap),
    .k_next  (k_nxt)
  );

  assign accept = bus.en && !bus.load;
  assign hit    = accept && (k_nxt == K_DET);

  // Match depth and the detect flag; z is registered alongside the state it decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      k_q <= '0;
      z_q <= 1'b0;
    end else if (bus.load) begin
      k_q <= '0;
      z_q <= 1'b0;
    end else if (bus.en) begin
      k_q <= k_nxt;
      z_q <= (k_nxt == K_DET);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= PAT_RST;
    end else if (bus.load) begin
      pat_q <= bus.pattern;
    end
  end

  // Clear wins over a coincident match; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.clr_cnt) begin
      cnt_q <= '0;
    end else if (hit && cnt_q != {CW{1'b1}}) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign bus.z     = z_q;
  assign bus.count = cnt_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Scoreboard bench for seq_detect_prog: two instances (8-bit and 2-bit counters)
// share one stimulus stream and are compared against a history-window model.
module tb_seq_detect_prog;

  typedef struct {
    int         id;
    logic       z;
    logic [7:0] c8;
    logic [1:0] c2;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_err  = 0;
  int n_step = 0;

  // Reference model: last accepted bits since the last restart point.
  logic [3:0] m_pat;
  logic [3:0] m_hist;
  int         m_hlen;
  logic       m_z;
  int         m_c8;
  int         m_c2;
  logic       ovl;

  seq_detect_prog_if #(.N(4), .CW(8)) ifa ();
  seq_detect_prog_if #(.N(4), .CW(2)) ifb ();

  assign ifb.x       = ifa.x;
  assign ifb.en      = ifa.en;
  assign ifb.load    = ifa.load;
  assign ifb.pattern = ifa.pattern;
  assign ifb.overlap = ifa.overlap;
  assign ifb.clr_cnt = ifa.clr_cnt;

  seq_detect_prog #(.N(4), .CW(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  seq_detect_prog #(.N(4), .CW(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pat  = 4'b1100;
    m_hist = 4'b0000;
    m_hlen = 0;
    m_z    = 1'b0;
    m_c8   = 0;
    m_c2   = 0;
  endtask

  // Drive one cycle of inputs and push the outputs expected after the next edge.
  task automatic step(input logic bx, input logic ben, input logic bload,
                      input logic [3:0] bpat, input logic bovl, input logic bclr);
    exp_t e;
    @(negedge clk);
    ifa.x       = bx;
    ifa.en      = ben;
    ifa.load    = bload;
    ifa.pattern = bpat;
    ifa.overlap = bovl;
    ifa.clr_cnt = bclr;

    if (bload) begin
      m_pat  = bpat;
      m_hlen = 0;
      m_z    = 1'b0;
    end else if (ben) begin
      if (m_z && !bovl) m_hlen = 0;
      m_hist = {m_hist[2:0], bx};
      if (m_hlen < 4) m_hlen++;
      m_z = (m_hlen == 4) && (m_hist == m_pat);
    end
    if (bclr) begin
      m_c8 = 0;
      m_c2 = 0;
    end else if (ben && !bload && m_z) begin
      if (m_c8 < 255) m_c8++;
      if (m_c2 < 3) m_c2++;
    end

    n_step++;
    e.id = n_step;
    e.z  = m_z;
    e.c8 = 8'(m_c8);
    e.c2 = 2'(m_c2);
    sb.push_back(e);
  endtask

  task automatic feed(input logic [7:0] bits, input int nb);
    logic [7:0] b;
    b = bits;
    for (int i = nb - 1; i >= 0; i--) step(b[i], 1'b1, 1'b0, m_pat, ovl, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, m_pat, ovl, 1'b0);
  endtask

  task automatic load_pat(input logic [3:0] p);
    step(1'b0, 1'b0, 1'b1, p, ovl, 1'b0);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic do_reset();
    @(posedge clk);
    #3;
    ifa.en      = 1'b0;
    ifa.load    = 1'b0;
    ifa.clr_cnt = 1'b0;
    rst_n       = 1'b0;
    #1;
    check("async_rst_z_a",   32'(ifa.z),     32'(0));
    check("async_rst_cnt_a", 32'(ifa.count), 32'(0));
    check("async_rst_z_b",   32'(ifb.z),     32'(0));
    check("async_rst_cnt_b", 32'(ifb.count), 32'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare both instances against the oldest expectation after each edge.
  always begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check($sformatf("z_a[%0d]", mon_e.id),     32'(ifa.z),     32'(mon_e.z));
      check($sformatf("z_b[%0d]", mon_e.id),     32'(ifb.z),     32'(mon_e.z));
      check($sformatf("count_a[%0d]", mon_e.id), 32'(ifa.count), 32'(mon_e.c8));
      check($sformatf("count_b[%0d]", mon_e.id), 32'(ifb.count), 32'(mon_e.c2));
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ifa.x       = 1'b0;
    ifa.en      = 1'b0;
    ifa.load    = 1'b0;
    ifa.pattern = 4'b0000;
    ifa.overlap = 1'b0;
    ifa.clr_cnt = 1'b0;
    ovl         = 1'b1;
    model_reset();

    #12;
    check("reset_z_a",     32'(ifa.z),     32'(0));
    check("reset_count_a", 32'(ifa.count), 32'(0));
    check("reset_count_b", 32'(ifb.count), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Default pattern 1100: detects after bits 4 and 8.
    feed(8'b1100_1100, 8);

    // 1010 overlapping: detects after bits 4, 6, 8.
    load_pat(4'b1010);
    feed(8'b1010_1010, 8);

    // 1010 non-overlapping: detects after bits 4 and 8.
    ovl = 1'b0;
    load_pat(4'b1010);
    feed(8'b1010_1010, 8);
    ovl = 1'b1;

    // en gap mid-pattern: state holds.
    load_pat(4'b1100);
    feed(8'b0000_0110, 3);
    repeat (3) idle();
    feed(8'b0000_0000, 1);

    // Load mid-pattern discards the partial match.
    load_pat(4'b1100);
    feed(8'b0000_0110, 3);
    load_pat(4'b0110);
    feed(8'b0000_0110, 4);

    // Saturation with back-to-back overlapping matches, then clear with a match.
    step(1'b0, 1'b0, 1'b0, m_pat, ovl, 1'b1);
    load_pat(4'b1111);
    feed(8'b1111_1111, 8);
    step(1'b1, 1'b1, 1'b0, m_pat, ovl, 1'b1);
    feed(8'b0000_0011, 2);

    // Load coincident with the final bit suppresses the match.
    load_pat(4'b1100);
    feed(8'b0000_0110, 3);
    step(1'b0, 1'b1, 1'b1, 4'b1100, ovl, 1'b0);

    // z held high while en is low.
    feed(8'b0000_1100, 4);
    repeat (2) idle();
    feed(8'b0000_0001, 1);

    // Randomised traffic.
    load_pat(4'($urandom));
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) ovl = ~ovl;
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 59) == 0),
           4'($urandom),
           ovl,
           ($urandom_range(0, 49) == 0));
    end

    // Reset mid-pattern (depth 3) restores the default pattern.
    ovl = 1'b1;
    load_pat(4'b0011);
    feed(8'b0000_0001, 3);
    do_reset();
    feed(8'b0000_0001, 1);
    feed(8'b0000_1100, 4);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
